// File: rtl/bus_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    WAIT    = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 8;
  localparam int GPIO_BIT = 8;

  // Pointer width that stays legal for a single-core build.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority.sv
// Round-robin pick: first requesting core at or after the pointer, wrapping.
module rr_priority
  import bus_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int PTR_W   = ptr_width(N_CORES)
) (
  input  logic [N_CORES-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [N_CORES-1:0] o_pick,
  output logic               o_valid
);

  logic [N_CORES-1:0]   w_rot;
  logic [N_CORES-1:0]   w_first;
  logic [2*N_CORES-1:0] w_back;

  // Rotate so the pointer position lands on bit 0; the pointer is always < N_CORES.
  assign w_rot = N_CORES'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated request vector.
  always_comb begin
    w_first = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N_CORES; j++) begin
      if (!o_valid && w_rot[j]) begin
        w_first[j] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

  // Rotate the one-hot result back into core numbering.
  assign w_back = {{N_CORES{1'b0}}, w_first} << i_ptr;
  assign o_pick = w_back[N_CORES-1:0] | w_back[2*N_CORES-1:N_CORES];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit RAM/GPIO bus between N_CORES cores.
// Every output is a register; strobes and grant lag the FSM state by one cycle,
// while addresses and write data are registered at the IDLE latch so that a
// synchronous RAM has its address a full cycle ahead of the read capture.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int RAM_LAT = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [N_CORES-1:0]          i_req,
  input  logic [N_CORES-1:0]          i_req_rw,
  input  logic [ADDR_W*N_CORES-1:0]   i_req_addr,
  input  logic [DATA_W*N_CORES-1:0]   i_req_wdata,
  output logic [N_CORES-1:0]          o_grant,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [7:0]                  o_ram_addr,
  output logic                        o_ram_we,
  output logic [DATA_W-1:0]           o_ram_wdata,
  input  logic [DATA_W-1:0]           i_ram_rdata,
  output logic [7:0]                  o_gpio_addr,
  output logic                        o_gpio_we,
  output logic [DATA_W-1:0]           o_gpio_wdata,
  input  logic [DATA_W-1:0]           i_gpio_rdata
);

  localparam int              PTR_W     = ptr_width(N_CORES);
  localparam logic [7:0]      WAIT_LOAD = (RAM_LAT > 1) ? 8'(RAM_LAT - 2) : 8'd0;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CORES - 1);

  arb_state_t          r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [N_CORES-1:0]  r_sel;
  logic                r_rw;
  logic                r_gpio;
  logic [7:0]          r_wait_cnt;
  logic [N_CORES-1:0]  r_grant;
  logic [DATA_W-1:0]   r_rdata;
  logic [7:0]          r_ram_addr;
  logic                r_ram_we;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [7:0]          r_gpio_addr;
  logic                r_gpio_we;
  logic [DATA_W-1:0]   r_gpio_wdata;

  logic [N_CORES-1:0]  w_pick;
  logic                w_valid;
  logic                w_rw;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [PTR_W-1:0]    w_sel_idx;
  logic [PTR_W-1:0]    w_ptr_next;

  rr_priority #(
    .N_CORES (N_CORES),
    .PTR_W   (PTR_W)
  ) u_rr_priority (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  // Route the picked core's request fields onto a single set of wires.
  always_comb begin
    w_rw    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (w_pick[i]) begin
        w_rw    = i_req_rw[i];
        w_addr  = i_req_addr[ADDR_W*i +: ADDR_W];
        w_wdata = i_req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Index of the core being served, and the pointer one past it.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (r_sel[i]) begin
        w_sel_idx = PTR_W'(i);
      end
    end
    w_ptr_next = (w_sel_idx == LAST_IDX) ? '0 : w_sel_idx + PTR_W'(1);
  end

  // Transaction FSM with the latched request and all registered bus outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_sel        <= '0;
      r_rw         <= 1'b0;
      r_gpio       <= 1'b0;
      r_wait_cnt   <= '0;
      r_grant      <= '0;
      r_rdata      <= '0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= '0;
      r_gpio_addr  <= '0;
      r_gpio_we    <= 1'b0;
      r_gpio_wdata <= '0;
    end else begin
      r_ram_we  <= 1'b0;
      r_gpio_we <= 1'b0;
      r_grant   <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_sel  <= w_pick;
            r_rw   <= w_rw;
            r_gpio <= w_addr[GPIO_BIT];
            if (w_addr[GPIO_BIT]) begin
              r_gpio_addr <= w_addr[7:0];
              if (w_rw) begin
                r_gpio_wdata <= w_wdata;
              end
            end else begin
              r_ram_addr <= w_addr[7:0];
              if (w_rw) begin
                r_ram_wdata <= w_wdata;
              end
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_rw) begin
            if (r_gpio) begin
              r_gpio_we <= 1'b1;
            end else begin
              r_ram_we <= 1'b1;
            end
          end
          // Only slow RAM reads need extra cycles before the capture.
          if (!r_rw && !r_gpio && (RAM_LAT > 1)) begin
            r_wait_cnt <= WAIT_LOAD;
            r_state    <= WAIT;
          end else begin
            r_state <= GRANT;
          end
        end
        WAIT: begin
          if (r_wait_cnt == 8'd0) begin
            r_state <= GRANT;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end
        GRANT: begin
          r_grant <= r_sel;
          if (!r_rw) begin
            r_rdata <= r_gpio ? i_gpio_rdata : i_ram_rdata;
          end
          r_ptr   <= w_ptr_next;
          r_state <= RELEASE;
        end
        RELEASE: begin
          // The served core still holds req this cycle; never sample here.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_rdata      = r_rdata;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_we     = r_ram_we;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_gpio_addr  = r_gpio_addr;
  assign o_gpio_we    = r_gpio_we;
  assign o_gpio_wdata = r_gpio_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: table of single accesses plus hand-written
// reset, simultaneous-request and continuous-request sequences.
module tb_bus_arbiter;

  localparam int NC = 2;

  logic            clk;
  logic            reset;
  logic [NC-1:0]   req;
  logic [NC-1:0]   req_rw;
  logic [9*NC-1:0] req_addr;
  logic [8*NC-1:0] req_wdata;
  logic [NC-1:0]   grant;
  logic [7:0]      rdata;
  logic [7:0]      ram_addr;
  logic            ram_we;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram_rdata;
  logic [7:0]      gpio_addr;
  logic            gpio_we;
  logic [7:0]      gpio_wdata;
  logic [7:0]      gpio_rdata;

  bus_arbiter #(.N_CORES(NC), .RAM_LAT(1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_req_rw     (req_rw),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_grant      (grant),
    .o_rdata      (rdata),
    .o_ram_addr   (ram_addr),
    .o_ram_we     (ram_we),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata),
    .o_gpio_addr  (gpio_addr),
    .o_gpio_we    (gpio_we),
    .o_gpio_wdata (gpio_wdata),
    .i_gpio_rdata (gpio_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: synchronous-read RAM, combinational-read GPIO bank.
  logic [7:0] mem [256];
  logic [7:0] gpio_regs [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]       <= 8'(i) ^ 8'h55;
      gpio_regs[i] <= ~8'(i);
    end
    mem[5]          <= 8'hA7;
    gpio_regs[8'hFF] <= 8'h81;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (gpio_we) gpio_regs[gpio_addr] <= gpio_wdata;
  end

  assign gpio_rdata = gpio_regs[gpio_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Scoreboard of expected grant pulses, in expected service order.
  typedef struct {
    int         core;
    logic [7:0] rdata;
  } sb_t;
  sb_t sb[$];

  int cyc       = 0;
  int last_g    = -100;
  int grant_cyc = 0;
  int we_cyc    = 0;
  int n_ram_we  = 0;
  int n_gpio_we = 0;

  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (ram_we) begin
      n_ram_we++;
      we_cyc = cyc;
    end
    if (gpio_we) begin
      n_gpio_we++;
      we_cyc = cyc;
    end
    if (grant != '0) begin
      check("grant_gap_ge4", 32'((cyc - last_g) >= 4), 32'd1);
      last_g    = cyc;
      grant_cyc = cyc;
      if (sb.size() == 0) begin
        check("sb_unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_grant", 32'(grant), 32'd1 << e.core);
        check("sb_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  // One core access: hold the request until its grant, then drop it a cycle later.
  task automatic do_access(input int c, input logic rw, input logic [8:0] addr,
                           input logic [7:0] wd, input int exp_lat);
    int n;
    int ram0;
    int gpio0;
    bit got;
    ram0  = n_ram_we;
    gpio0 = n_gpio_we;
    req_rw[c]          = rw;
    req_addr[9*c +: 9] = addr;
    req_wdata[8*c +: 8] = wd;
    req[c]             = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (grant[c]) got = 1'b1;
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) begin
      #1;
      if (exp_lat > 0) check("grant_latency", 32'(n), 32'(exp_lat));
      if (addr[8]) check("gpio_addr", 32'(gpio_addr), 32'(addr[7:0]));
      else         check("ram_addr", 32'(ram_addr), 32'(addr[7:0]));
      if (exp_lat > 0) begin
        check("ram_we_count", 32'(n_ram_we - ram0), 32'((rw && !addr[8]) ? 1 : 0));
        check("gpio_we_count", 32'(n_gpio_we - gpio0), 32'((rw && addr[8]) ? 1 : 0));
        if (rw) begin
          check("we_to_grant", 32'(grant_cyc - we_cyc), 32'd1);
          if (addr[8]) check("gpio_wdata", 32'(gpio_wdata), 32'(wd));
          else         check("ram_wdata", 32'(ram_wdata), 32'(wd));
        end
      end
    end
    @(posedge clk);
    #1 req[c] = 1'b0;
  endtask

  typedef struct {
    int         core;
    logic       rw;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int g;
    reset     = 1'b1;
    req       = '0;
    req_rw    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Write after a read must leave rdata holding the last read value.
    tbl[0] = '{0, 1'b0, 9'h005, 8'h00, 8'hA7};
    tbl[1] = '{1, 1'b1, 9'h010, 8'h3C, 8'hA7};
    tbl[2] = '{0, 1'b0, 9'h010, 8'h00, 8'h3C};
    tbl[3] = '{1, 1'b0, 9'h1FF, 8'h00, 8'h81};
    tbl[4] = '{0, 1'b1, 9'h120, 8'h5A, 8'h81};
    tbl[5] = '{0, 1'b0, 9'h120, 8'h00, 8'h5A};
    tbl[6] = '{1, 1'b0, 9'h020, 8'h00, 8'h75};
    tbl[7] = '{1, 1'b1, 9'h0FF, 8'hE1, 8'h75};
    tbl[8] = '{0, 1'b0, 9'h0FF, 8'h00, 8'hE1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_we", 32'({ram_we, gpio_we}), 32'd0);
    check("rst_addr", 32'({ram_addr, gpio_addr, ram_wdata, gpio_wdata}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      sb.push_back('{tbl[i].core, tbl[i].exp_rdata});
      do_access(tbl[i].core, tbl[i].rw, tbl[i].addr, tbl[i].wdata, 4);
    end

    // Reset in the middle of a RAM write: strobe drops without a clock edge.
    req_rw[1]       = 1'b1;
    req_addr[17:9]  = 9'h033;
    req_wdata[15:8] = 8'h99;
    req[1]          = 1'b1;
    n = 0;
    while (!ram_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_we_seen", 32'(ram_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_we_drop", 32'(ram_we), 32'd0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_rdata", 32'(rdata), 32'd0);
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // The aborted write never reached the RAM.
    sb.push_back('{1, 8'h66});
    do_access(1, 1'b0, 9'h033, 8'h00, 4);

    // Simultaneous requests with the pointer at 0, twice.
    for (int p = 0; p < 2; p++) begin
      sb.push_back('{0, 8'hA7});
      sb.push_back('{1, 8'h81});
      fork
        do_access(0, 1'b0, 9'h005, 8'h00, 0);
        do_access(1, 1'b0, 9'h1FF, 8'h00, 0);
      join
    end

    // Core0 requests continuously, core1 joins once: 0,1,0.
    sb.push_back('{0, 8'hA7});
    sb.push_back('{1, 8'h81});
    sb.push_back('{0, 8'hA7});
    @(posedge clk);
    #1;
    req_rw         = '0;
    req_addr[8:0]  = 9'h005;
    req[0]         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_addr[17:9] = 9'h1FF;
    req[1]         = 1'b1;
    g = 0;
    n = 0;
    while (g < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (grant != '0) begin
        g++;
        if (grant[1]) begin
          @(posedge clk);
          #1 req[1] = 1'b0;
        end
      end
    end
    check("hold_grant_count", 32'(g), 32'd3);
    @(posedge clk);
    #1 req[0] = 1'b0;

    repeat (8) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
